iter_alu: RTL and testbench

- Parametrised, multicycle successor to the single-cycle datapath ALU.
- Keeps the 12 one-hot single-cycle operations.
- Adds iterative signed/unsigned multiply (shift-add) and divide (restoring), with a 64-bit-style {hi, lo} result.
- Valid/ready handshakes on input and output; sits in the EX stage of the multicycle CPU, which stalls on in_ready/out_valid.

---
 rtl/iter_alu.sv | 236 +++++++++++++++++++++++
 tb/tb_iter_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multicycle ALU: one-hot single-cycle ops plus iterative shift-add multiply and restoring divide.
// Optional macro ITER_ALU_EARLY_TERM_EN stops a multiply once the remaining multiplier bits are zero.
module iter_alu #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5,
   parameter int OP_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [OP_WIDTH-1:0]   ALUop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Result,
   output logic [DATA_WIDTH-1:0] Result_hi,
   output logic                  Overflow,
   output logic                  CarryOut,
   output logic                  Zero,
   output logic                  DivByZero
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = SHAMT_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_neg_q, r_neg_r, r_div_ovf;
   logic [2*W-1:0]      r_acc, r_mcand;
   logic [W-1:0]        r_mplr, r_rem, r_quo, r_dvsr;
   logic [W-1:0]        r_result, r_result_hi;
   logic                r_ovf, r_cout, r_zero, r_dbz;

   logic                w_accept, w_onehot, w_is_mul, w_is_div, w_signed_op, w_b_zero;
   logic [W-1:0]        w_a_mag, w_b_mag;
   logic [W:0]          w_sum, w_diff;
   logic [W-1:0]        w_sc_res;
   logic                w_sc_ovf, w_sc_cout;
   logic [2*W-1:0]      w_acc_nxt, w_prod;
   logic [W-1:0]        w_mplr_nxt;
   logic                w_mul_last, w_div_last;
   logic [W:0]          w_shift, w_trial;
   logic [W-1:0]        w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign Result    = r_result;
   assign Result_hi = r_result_hi;
   assign Overflow  = r_ovf;
   assign CarryOut  = r_cout;
   assign Zero      = r_zero;
   assign DivByZero = r_dbz;

   assign w_accept    = in_valid && (r_state == S_IDLE);
   assign w_onehot    = (ALUop != '0) && ((ALUop & (ALUop - 1'b1)) == '0);
   assign w_is_mul    = ALUop[12] | ALUop[13];
   assign w_is_div    = ALUop[14] | ALUop[15];
   assign w_signed_op = ALUop[12] | ALUop[14];
   assign w_b_zero    = (B == '0);
   assign w_a_mag     = (w_signed_op && A[W-1]) ? -A : A;
   assign w_b_mag     = (w_signed_op && B[W-1]) ? -B : B;

   assign w_sum  = {1'b0, A} + {1'b0, B};
   assign w_diff = {1'b0, A} + {1'b0, ~B} + (W+1)'(1);

   always_comb begin
      w_sc_res  = '0;
      w_sc_ovf  = 1'b0;
      w_sc_cout = 1'b0;
      if (ALUop[0]) begin
         w_sc_res  = w_sum[W-1:0];
         w_sc_cout = w_sum[W];
         w_sc_ovf  = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end else if (ALUop[1]) begin
         w_sc_res  = w_diff[W-1:0];
         w_sc_cout = w_diff[W];
         w_sc_ovf  = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
      end else if (ALUop[2]) begin
         w_sc_res = A & B;
      end else if (ALUop[3]) begin
         w_sc_res = A | B;
      end else if (ALUop[4]) begin
         w_sc_res = ~(A | B);
      end else if (ALUop[5]) begin
         w_sc_res = A ^ B;
      end else if (ALUop[6]) begin
         w_sc_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      end else if (ALUop[7]) begin
         w_sc_res = {{(W-1){1'b0}}, (A < B)};
      end else if (ALUop[8]) begin
         w_sc_res = B << A[SHAMT_WIDTH-1:0];
      end else if (ALUop[9]) begin
         w_sc_res = B >> A[SHAMT_WIDTH-1:0];
      end else if (ALUop[10]) begin
         w_sc_res = $signed(B) >>> A[SHAMT_WIDTH-1:0];
      end else if (ALUop[11]) begin
         w_sc_res = {B[W/2-1:0], {(W/2){1'b0}}};
      end
   end

   // The final iteration writes the result directly, so latency stays at iterations + 1.
   assign w_acc_nxt  = r_acc + (r_mplr[0] ? r_mcand : '0);
   assign w_prod     = r_neg_q ? -w_acc_nxt : w_acc_nxt;
   assign w_mplr_nxt = r_mplr >> 1;
`ifdef ITER_ALU_EARLY_TERM_EN
   assign w_mul_last = (r_cnt == CNT_W'(1)) || (w_mplr_nxt == '0);
`else
   assign w_mul_last = (r_cnt == CNT_W'(1));
`endif

   assign w_shift    = {r_rem, r_quo[W-1]};
   assign w_trial    = w_shift - {1'b0, r_dvsr};
   assign w_rem_nxt  = w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
   assign w_quo_nxt  = {r_quo[W-2:0], ~w_trial[W]};
   assign w_q_fin    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
   assign w_r_fin    = r_neg_r ? -w_rem_nxt : w_rem_nxt;
   assign w_div_last = (r_cnt == CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_onehot)                   w_state_nxt = S_DONE;
               else if (w_is_mul)               w_state_nxt = S_MUL;
               else if (w_is_div && !w_b_zero)  w_state_nxt = S_DIV;
               else                             w_state_nxt = S_DONE;
            end
         end
         S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
         S_DIV:  if (w_div_last) w_state_nxt = S_DONE;
         S_DONE: if (out_ready)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_div_ovf   <= 1'b0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvsr      <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_ovf       <= 1'b0;
         r_cout      <= 1'b0;
         r_zero      <= 1'b1;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt     <= CNT_W'(W);
                  r_neg_q   <= w_signed_op && (A[W-1] ^ B[W-1]);
                  r_neg_r   <= ALUop[14] && A[W-1];
                  r_div_ovf <= ALUop[14] && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
                  if (!w_onehot) begin
                     r_result    <= '0;
                     r_result_hi <= '0;
                     r_ovf       <= 1'b0;
                     r_cout      <= 1'b0;
                     r_zero      <= 1'b1;
                     r_dbz       <= 1'b0;
                  end else if (w_is_mul) begin
                     r_acc   <= '0;
                     r_mcand <= {{W{1'b0}}, w_a_mag};
                     r_mplr  <= w_b_mag;
                  end else if (w_is_div) begin
                     if (w_b_zero) begin
                        r_result    <= '1;
                        r_result_hi <= A;
                        r_ovf       <= 1'b0;
                        r_cout      <= 1'b0;
                        r_zero      <= 1'b0;
                        r_dbz       <= 1'b1;
                     end else begin
                        r_rem  <= '0;
                        r_quo  <= w_a_mag;
                        r_dvsr <= w_b_mag;
                     end
                  end else begin
                     r_result    <= w_sc_res;
                     r_result_hi <= '0;
                     r_ovf       <= w_sc_ovf;
                     r_cout      <= w_sc_cout;
                     r_zero      <= (w_sc_res == '0);
                     r_dbz       <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               r_acc   <= w_acc_nxt;
               r_mcand <= r_mcand << 1;
               r_mplr  <= w_mplr_nxt;
               r_cnt   <= r_cnt - 1'b1;
               if (w_mul_last) begin
                  r_result    <= w_prod[W-1:0];
                  r_result_hi <= w_prod[2*W-1:W];
                  r_ovf       <= 1'b0;
                  r_cout      <= 1'b0;
                  r_zero      <= (w_prod[W-1:0] == '0);
                  r_dbz       <= 1'b0;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (w_div_last) begin
                  r_result    <= w_q_fin;
                  r_result_hi <= w_r_fin;
                  r_ovf       <= r_div_ovf;
                  r_cout      <= 1'b0;
                  r_zero      <= (w_q_fin == '0);
                  r_dbz       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu: vector table plus hand sequences for
// hold/backpressure/reset; latency expectations follow ITER_ALU_EARLY_TERM_EN.
module tb_iter_alu;
   localparam logic [15:0] OP_ADD  = 16'h0001, OP_SUB  = 16'h0002, OP_AND = 16'h0004,
                           OP_OR   = 16'h0008, OP_NOR  = 16'h0010, OP_XOR = 16'h0020,
                           OP_SLT  = 16'h0040, OP_SLTU = 16'h0080, OP_SLL = 16'h0100,
                           OP_SRL  = 16'h0200, OP_SRA  = 16'h0400, OP_LUI = 16'h0800,
                           OP_MUL  = 16'h1000, OP_MULU = 16'h2000, OP_DIV = 16'h4000,
                           OP_DIVU = 16'h8000;

   logic        clk = 1'b0;
   logic        resetn, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] A, B, Result, Result_hi;
   logic [15:0] ALUop;
   logic        Overflow, CarryOut, Zero, DivByZero;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] op;
      logic [31:0] a, b, res, hi;
      logic [3:0]  fl;   // {Overflow, CarryOut, Zero, DivByZero}
      int          lat;
   } vec_t;
   vec_t tv[$];

   iter_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .OP_WIDTH(16)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Result_hi(Result_hi), .Overflow(Overflow),
      .CarryOut(CarryOut), .Zero(Zero), .DivByZero(DivByZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int mul_lat(input logic sgn, input logic [31:0] b);
      logic [31:0] mag;
      int idx;
      mag = (sgn && b[31]) ? -b : b;
      idx = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
`ifdef ITER_ALU_EARLY_TERM_EN
      return 1 + ((idx + 1) > 1 ? (idx + 1) : 1);
`else
      return 33;
`endif
   endfunction

   task automatic addv(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] hi, input logic [3:0] fl,
                       input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.fl = fl; v.lat = lat;
      tv.push_back(v);
   endtask

   task automatic do_accept(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
      @(negedge clk);
      ALUop = op; A = a; B = b; in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_after_take", out_valid, 0);
   endtask

   initial begin
      int lat;
      logic bp_ok;

      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALUop = '0;

      addv(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 4'b1000, 1);
      addv(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 4'b0110, 1);
      addv(OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 0, 4'b0110, 1);
      addv(OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 4'b0000, 1);
      addv(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 4'b1100, 1);
      addv(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 4'b0000, 1);
      addv(OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0, 4'b0000, 1);
      addv(OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 4'b0000, 1);
      addv(OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 0, 4'b0000, 1);
      addv(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 4'b0000, 1);
      addv(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 4'b0010, 1);
      addv(OP_SLL,  32'hFFFFFFE4, 32'h0000000F, 32'h000000F0, 0, 4'b0000, 1);
      addv(OP_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 0, 4'b0000, 1);
      addv(OP_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 0, 4'b0000, 1);
      addv(OP_LUI,  32'h00000000, 32'h1234ABCD, 32'hABCD0000, 0, 4'b0000, 1);
      addv(OP_MUL,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b0000, mul_lat(1, 32'h3));
      addv(OP_MULU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'h00000002, 4'b0000, mul_lat(0, 32'h3));
      addv(OP_MUL,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0000000F, 32'h00000000, 4'b0000, mul_lat(1, 32'hFFFFFFFB));
      addv(OP_MULU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 4'b0010, mul_lat(0, 32'h10000));
      addv(OP_MUL,  32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0010, mul_lat(1, 32'h0));
      addv(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0000, 33);
      addv(OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000003, 32'h00000001, 4'b0000, 33);
      addv(OP_DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 4'b0001, 1);
      addv(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b1000, 33);
      addv(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 4'b0000, 33);
      addv(OP_DIV,  32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 4'b0001, 1);
      addv(OP_DIVU, 32'h00000003, 32'h00000007, 32'h00000000, 32'h00000003, 4'b0010, 33);
      addv(16'h0000, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 4'b0010, 1);
      addv(16'h0003, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 4'b0010, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", {Result_hi, Result}, 64'h0);
      chk("reset_flags", {Overflow, CarryOut, Zero, DivByZero}, 4'b0010);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         do_accept(tv[i].op, tv[i].a, tv[i].b, lat);
         chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
         chk($sformatf("v%0d_result", i), {Result_hi, Result}, {tv[i].hi, tv[i].res});
         chk($sformatf("v%0d_flags", i), {Overflow, CarryOut, Zero, DivByZero}, tv[i].fl);
         take_result();
      end

      // Result held under out_ready=0
      do_accept(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
      chk("hold_latency", lat, 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d", k), {out_valid, Result, Overflow, Zero}, {1'b1, 32'h80000000, 1'b1, 1'b0});
      end
      take_result();
      chk("in_ready_after_take", in_ready, 1);

      // Second request during MUL is ignored; out_ready outside DONE is ignored
      @(negedge clk);
      ALUop = OP_MULU; A = 32'd9; B = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      ALUop = OP_ADD; A = 32'd1; B = 32'd1; out_ready = 1'b1;
      lat = 1; bp_ok = 1'b1;
      while (!out_valid && lat < 200) begin
         if (in_ready) bp_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_in_ready_low", bp_ok, 1);
      chk("bp_latency", lat, mul_lat(0, 32'd3));
      chk("bp_result", {Result_hi, Result}, {32'h0, 32'd27});
      take_result();

      // Result left nonzero, then reset during MUL iteration 10
      do_accept(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
      take_result();
      @(negedge clk);
      ALUop = OP_MUL; A = 32'h12345; B = 32'hFFFF0001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("midreset_state", {in_ready, out_valid}, 2'b10);
      chk("midreset_result", Result, 32'h0);
      chk("midreset_zero", Zero, 1);
      @(negedge clk);
      resetn = 1'b1;

      do_accept(OP_ADD, 32'd2, 32'd3, lat);
      chk("post_reset_add", {lat[7:0], Result}, {8'd1, 32'd5});
      take_result();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
